// File: rtl/alu_rvs_stream_if.sv
// Request/result stream bundle for the bit-reverse ALU front-end.
interface alu_rvs_stream_if #(
  parameter int unsigned TAG_W = 4
);
  // Request side
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_din;
  logic [2:0]       s_funct;
  logic [TAG_W-1:0] s_tag;
  // Result side
  logic             m_valid;
  logic             m_ready;
  logic [31:0]      m_res;
  logic [TAG_W-1:0] m_tag;
  logic             m_err;

  // Block side: consumes requests, produces results
  modport slave (
    input  s_valid, s_din, s_funct, s_tag, m_ready,
    output s_ready, m_valid, m_res, m_tag, m_err
  );

  // Environment side: issues requests, accepts results
  modport master (
    output s_valid, s_din, s_funct, s_tag, m_ready,
    input  s_ready, m_valid, m_res, m_tag, m_err
  );
endinterface

// File: rtl/alu_rvs_stream.sv
// Streaming bit-reverse ALU: request FIFO, combinational reverse on the head,
// registered valid/ready result stage and a saturating illegal-funct counter.
module alu_rvs_stream #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  alu_rvs_stream_if.slave          bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              illegal_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // FIFO storage and pointers
  logic [31:0]      r_mem_din   [DEPTH];
  logic [2:0]       r_mem_funct [DEPTH];
  logic [TAG_W-1:0] r_mem_tag   [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Output stage
  logic             r_m_valid;
  logic [31:0]      r_m_res;
  logic [TAG_W-1:0] r_m_tag;
  logic             r_m_err;
  logic [15:0]      r_illegal_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_s_ready;
  logic             w_push;
  logic             w_load;
  logic [31:0]      w_head_din;
  logic [2:0]       w_head_funct;
  logic [TAG_W-1:0] w_head_tag;
  logic [4:0]       w_mask;
  logic [4:0]       w_idx;
  logic [31:0]      w_rev;
  logic [31:0]      w_res;
  logic             w_err;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Ready never looks at s_valid; full blocks even when a pop is pending.
  assign w_s_ready = !w_full && !flush;
  assign w_push    = bus.s_valid && w_s_ready;
  // Flush wins over a load, so the head is neither popped nor registered.
  assign w_load    = !w_empty && (!r_m_valid || bus.m_ready) && !flush;

  assign w_head_din   = r_mem_din[r_rptr];
  assign w_head_funct = r_mem_funct[r_rptr];
  assign w_head_tag   = r_mem_tag[r_rptr];

  // Reverse datapath: reversing inside aligned 2^k groups is an XOR of the bit index
  always_comb begin
    w_mask = '0;
    w_err  = 1'b0;
    w_idx  = '0;
    w_rev  = '0;
    case (w_head_funct)
      3'd0:    w_mask = 5'd0;
      3'd1:    w_mask = 5'd1;
      3'd2:    w_mask = 5'd3;
      3'd3:    w_mask = 5'd7;
      3'd4:    w_mask = 5'd15;
      default: w_err  = 1'b1;
    endcase
    for (int i = 0; i < 32; i++) begin
      w_idx    = 5'(i) ^ w_mask;
      w_rev[i] = w_head_din[w_idx];
    end
    w_res = w_err ? 32'hDEADBEEF : w_rev;
  end

  // FIFO storage write; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_din[r_wptr]   <= bus.s_din;
      r_mem_funct[r_wptr] <= bus.s_funct;
      r_mem_tag[r_wptr]   <= bus.s_tag;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_load) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: load from head, or drop valid once the consumer takes the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_res   <= '0;
      r_m_tag   <= '0;
      r_m_err   <= 1'b0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_res   <= w_res;
      r_m_tag   <= w_head_tag;
      r_m_err   <= w_err;
    end else if (r_m_valid && bus.m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  // Saturating count of illegal results entering the output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_load && w_err && (r_illegal_cnt != 16'hFFFF)) begin
      r_illegal_cnt <= r_illegal_cnt + 16'd1;
    end
  end

  assign bus.s_ready  = w_s_ready;
  assign bus.m_valid  = r_m_valid;
  assign bus.m_res    = r_m_res;
  assign bus.m_tag    = r_m_tag;
  assign bus.m_err    = r_m_err;
  assign count        = r_count;
  assign illegal_cnt  = r_illegal_cnt;

endmodule

// File: tb/tb_alu_rvs_stream.sv
// Self-checking bench for alu_rvs_stream: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_alu_rvs_stream;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]      din;
    logic [2:0]       funct;
    logic [TAG_W-1:0] tag;
  } req_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [CW-1:0] count;
  logic [15:0]   illegal_cnt;

  alu_rvs_stream_if #(.TAG_W(TAG_W)) bus ();

  alu_rvs_stream #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .count       (count),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  req_t             q[$];
  logic             mv;
  logic [31:0]      mres;
  logic [TAG_W-1:0] mtag;
  logic             merr;
  int unsigned      ill;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reverse by explicit group/offset arithmetic; returns {err, res}
  function automatic logic [32:0] rev_ref(input logic [31:0] d, input logic [2:0] f);
    logic [31:0] r;
    int          b;
    if (f == 3'd0) return {1'b0, d};
    if (f > 3'd4)  return {1'b1, 32'hDEADBEEF};
    b = 1 << f;
    r = '0;
    for (int g = 0; g < 32; g += b)
      for (int j = 0; j < b; j++)
        r[g + b - 1 - j] = d[g + j];
    return {1'b0, r};
  endfunction

  task automatic model_reset();
    q.delete();
    mv   = 1'b0;
    mres = '0;
    mtag = '0;
    merr = 1'b0;
    ill  = 0;
  endtask

  task automatic check_outputs();
    check_eq("m_valid", 32'(bus.m_valid), 32'(mv));
    check_eq("m_res", bus.m_res, mres);
    check_eq("m_tag", 32'(bus.m_tag), 32'(mtag));
    check_eq("m_err", 32'(bus.m_err), 32'(merr));
    check_eq("count", 32'(count), q.size());
    check_eq("illegal_cnt", 32'(illegal_cnt), ill);
  endtask

  // One clock cycle, entered and left at a falling edge
  task automatic step(input logic sv, input logic [31:0] din, input logic [2:0] funct,
                      input logic [TAG_W-1:0] tag, input logic mr, input logic fl);
    logic        exp_ready;
    logic        push;
    logic        load;
    logic [32:0] rr;
    req_t        h;
    bus.s_valid = sv;
    bus.s_din   = din;
    bus.s_funct = funct;
    bus.s_tag   = tag;
    bus.m_ready = mr;
    flush       = fl;
    #1;
    exp_ready = (q.size() < DEPTH) && !fl;
    check_eq("s_ready", 32'(bus.s_ready), 32'(exp_ready));
    push = sv && exp_ready;
    load = (q.size() > 0) && (!mv || mr) && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
      mv = 1'b0;
    end else begin
      if (load) begin
        h    = q.pop_front();
        rr   = rev_ref(h.din, h.funct);
        mv   = 1'b1;
        mres = rr[31:0];
        merr = rr[32];
        mtag = h.tag;
        if (rr[32] && ill != 32'hFFFF) ill++;
      end else if (mv && mr) begin
        mv = 1'b0;
      end
      if (push) q.push_back('{din: din, funct: funct, tag: tag});
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic mr);
    step(1'b0, 32'h0, 3'd0, '0, mr, 1'b0);
  endtask

  logic [31:0] v_din [5];
  logic [2:0]  v_fn  [5];
  logic [31:0] v_exp [5];

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_din   = '0;
    bus.s_funct = '0;
    bus.s_tag   = '0;
    bus.m_ready = 1'b0;
    model_reset();

    // Reset state
    #3;
    check_eq("reset_s_ready", 32'(bus.s_ready), 32'd1);
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request: result one cycle after the accept edge
    step(1'b1, 32'h12345678, 3'd3, 4'd1, 1'b1, 1'b0);
    check_eq("lat_not_yet", 32'(bus.m_valid), 32'd0);
    idle(1'b1);
    check_eq("lat_valid", 32'(bus.m_valid), 32'd1);
    check_eq("f3_res", bus.m_res, 32'h482C6A1E);
    check_eq("f3_tag", 32'(bus.m_tag), 32'd1);
    idle(1'b1);

    // Back-to-back pushes, results on consecutive cycles
    v_din = '{32'h12345678, 32'h00000001, 32'h00010001, 32'hCAFEF00D, 32'h0};
    v_fn  = '{3'd2, 3'd1, 3'd4, 3'd0, 3'd0};
    v_exp = '{32'h84C2A6E1, 32'h00000002, 32'h80008000, 32'hCAFEF00D, 32'h0};
    for (int i = 0; i < 4; i++) step(1'b1, v_din[i], v_fn[i], TAG_W'(i + 2), 1'b1, 1'b0);
    check_eq("b2b_0", bus.m_res, v_exp[2]);
    idle(1'b1);
    check_eq("b2b_1", bus.m_res, v_exp[3]);
    idle(1'b1);
    idle(1'b1);

    // Illegal funct, then a legal one
    step(1'b1, 32'h0, 3'd6, 4'd9, 1'b1, 1'b0);
    step(1'b1, 32'h12345678, 3'd3, 4'd10, 1'b1, 1'b0);
    check_eq("ill_res", bus.m_res, 32'hDEADBEEF);
    check_eq("ill_err", 32'(bus.m_err), 32'd1);
    check_eq("ill_cnt", 32'(illegal_cnt), 32'd1);
    idle(1'b1);
    check_eq("legal_err", 32'(bus.m_err), 32'd0);
    idle(1'b1);

    // Backpressure: DEPTH+1 requests fill output stage and FIFO, then drain
    for (int i = 0; i < DEPTH + 1; i++)
      step(1'b1, $urandom, 3'($urandom_range(0, 7)), TAG_W'(i), 1'b0, 1'b0);
    check_eq("full_count", 32'(count), DEPTH);
    step(1'b1, 32'hFFFF0000, 3'd1, 4'd15, 1'b0, 1'b0);
    check_eq("full_ready", 32'(bus.s_ready), 32'd0);
    for (int i = 0; i < DEPTH + 3; i++) idle(1'b1);

    // Flush with three queued entries and a held result
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 3'd5, TAG_W'(i), 1'b0, 1'b0);
    check_eq("pre_flush_count", 32'(count), 32'd3);
    step(1'b1, 32'hAAAA5555, 3'd2, 4'd12, 1'b0, 1'b1);
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_valid", 32'(bus.m_valid), 32'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 3'd3, TAG_W'(i), 1'b0, 1'b0);
    bus.s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(bus.m_valid), 32'd0);
    check_eq("arst_count", 32'(count), 32'd0);
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h00000F0F, 3'd4, 4'd7, 1'b1, 1'b0);
    idle(1'b1);
    check_eq("post_rst_tag", 32'(bus.m_tag), 32'd7);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)),
           TAG_W'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rvs_stream.md
Name: alu_rvs_stream

Overview:
Streaming front-end for the bit-reverse ALU. It accepts {din, funct, tag} requests over a valid/ready interface and buffers them in a DEPTH-entry FIFO. It drives the FIFO head through the combinational reverse datapath and registers the result into a valid/ready output stage. Illegal funct codes are flagged per result and counted. The block sits between the instruction-issue logic and the result writeback.

Parameters:
DEPTH, 4, request FIFO entries; power of 2, >= 2
TAG_W, 4, width of the request tag carried alongside each result

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of FIFO and output stage
s_valid  input  1  request valid
s_ready  output  1  request ready
s_din  input  32  operand
s_funct  input  3  reverse mode
s_tag  input  TAG_W  request tag
m_valid  output  1  result valid
m_ready  input  1  result ready
m_res  output  32  result
m_tag  output  TAG_W  tag of the result
m_err  output  1  result came from an illegal funct
count  output  $clog2(DEPTH)+1  FIFO occupancy, excluding the output stage
illegal_cnt  output  16  saturating count of illegal results delivered

Behaviour:
- Reverse function, applied to the FIFO head:
  - funct 0: res = din.
  - funct 1/2/3/4: reverse bit order inside each 2/4/8/16-bit group. Groups stay in place: bit j of a group of size B moves to bit B-1-j.
  - funct 5-7: illegal. res = 32'hDEADBEEF, err = 1.
- Reset (rst_n low, asynchronous): FIFO empty, count = 0, m_valid = 0, m_res = 0, m_tag = 0, m_err = 0, illegal_cnt = 0. s_ready = 1 once rst_n is low.
- s_ready = !full & !flush. It is combinational from state and flush and never depends on s_valid.
- Push: s_valid & s_ready at a rising edge writes the entry at the tail.
- Full FIFO blocks the push even if a pop happens in the same cycle. There is no full-bypass.
- Output stage load condition: FIFO non-empty & (!m_valid | m_ready).
  - On load: pop the head, register res/err/tag, set m_valid = 1.
- If m_valid & m_ready and the FIFO is empty: m_valid = 0. m_res, m_tag and m_err hold their last values.
- While m_valid & !m_ready: m_res, m_tag and m_err are stable and the FIFO does not pop.
- Latency: a request accepted at edge E with both stages empty shows m_valid = 1 after edge E+1.
- Throughput: one result per cycle when m_ready is held high.
- Simultaneous push and pop on a non-full FIFO: count unchanged, data order preserved. Pointers wrap modulo DEPTH.
- Empty FIFO is never read. There is no pass-through from s_* to m_* in the same cycle.
- flush (sampled at the edge): FIFO empty, count = 0, m_valid = 0. Any push that cycle is dropped (s_ready is already 0). illegal_cnt is unchanged.
- flush overrides load and pop that cycle.
- illegal_cnt increments by 1 on each output-stage load with err = 1. It saturates at 16'hFFFF.
- Reset asserted mid-stream discards all entries immediately. The first accepted request after release is the first result.

Test Plan:
- Reset, then push din=32'h12345678 with funct=3, tag=1, m_ready=1 -> m_res=32'h482C6A1E, m_tag=1, m_err=0, m_valid high 1 cycle after the accept edge.
- Back-to-back pushes with m_ready=1:
  - (32'h12345678, f=2) -> 32'h84C2A6E1
  - (32'h00000001, f=1) -> 32'h00000002
  - (32'h00010001, f=4) -> 32'h80008000
  - (32'hCAFEF00D, f=0) -> 32'hCAFEF00D
  - Results arrive on consecutive cycles, in order.
- funct=6 with din=0 -> m_res=32'hDEADBEEF, m_err=1, illegal_cnt 0->1. A following funct=3 result has m_err=0.
- m_ready=0, push DEPTH+1 requests -> the output stage holds 1 result, then the FIFO fills: count=DEPTH, s_ready=0. m_res stays stable; raise m_ready -> all DEPTH+1 results drain in order.
- With the FIFO holding 3 entries and m_valid=1, pulse flush alongside s_valid=1 -> next cycle count=0, m_valid=0, the flushed push is never output, illegal_cnt unchanged.
- Deassert rst_n asynchronously mid-stream -> m_valid and count drop to 0 without a clock edge. After release, push tag=7 -> the first result has m_tag=7.
